// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_stage_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 8-bit RISC with a variable-latency req/ack data-memory access,
// upstream stall while an access is outstanding, sticky timeout flag and the MEM/WB register.
module mem_stage #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite_exmem_i,
  input  logic              memread_exmem_i,
  input  logic              memwrite_exmem_i,
  input  logic              mem_to_reg_exmem_i,
  input  logic [DATA_W-1:0] alu_result_exmem_i,
  input  logic [DATA_W-1:0] write_data_exmem_i,
  input  logic [2:0]        rd_exmem_i,
  output logic              stall_o,
  mem_stage_if.master       dmem,
  output logic              err_o,
  output logic              regwrite_memwb_o,
  output logic              mem_to_reg_memwb_o,
  output logic [DATA_W-1:0] wb_data_memwb_o,
  output logic [2:0]        rd_memwb_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] wb_nx;
  logic op, done;
  assign op = memread_exmem_i | memwrite_exmem_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (op ? BUSY : IDLE) : (done ? IDLE : BUSY);
  end
  // Timeout completes like an ack with zero read data; stall is masked during reset.
  always_comb begin
    done = state == BUSY && (dmem.ack || cnt == CW'(TIMEOUT - 1));
    stall_o = !rst && (state == IDLE ? op : !done);
    wb_nx = (state == BUSY && mem_to_reg_exmem_i) ? ((dmem.ack && !dmem.we) ? dmem.rdata : '0)
                                                  : alu_result_exmem_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem.req           <= 1'b0;
      dmem.we            <= 1'b0;
      dmem.addr          <= '0;
      dmem.wdata         <= '0;
      cnt                <= '0;
      err_o              <= 1'b0;
      regwrite_memwb_o   <= 1'b0;
      mem_to_reg_memwb_o <= 1'b0;
      wb_data_memwb_o    <= '0;
      rd_memwb_o         <= '0;
    end else begin
      dmem.req <= state_nx == BUSY;
      if (state == IDLE && op) begin
        dmem.we    <= memwrite_exmem_i;
        dmem.addr  <= alu_result_exmem_i[ADDR_W-1:0];
        dmem.wdata <= write_data_exmem_i;
      end
      cnt                <= state == BUSY ? cnt + CW'(1) : '0;
      err_o              <= err_o | (done && !dmem.ack);
      regwrite_memwb_o   <= !stall_o && regwrite_exmem_i;
      mem_to_reg_memwb_o <= !stall_o && mem_to_reg_exmem_i;
      wb_data_memwb_o    <= stall_o ? '0 : wb_nx;
      rd_memwb_o         <= stall_o ? '0 : rd_exmem_i;
    end
  end
endmodule
